// File: rtl/parser_seq_checker.sv
// Parser bring-up self-check: compares {state, lit, copy} each cycle against a
// programmable expected sequence. Optional mismatch capture: PARSER_SEQ_CHK_CAPTURE_EN.
module parser_seq_checker #(
  parameter int STATE_W = 3,
  parameter int DEPTH   = 16,
  parameter int IDX_W   = 4,
  parameter bit GATED   = 1'b0
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [STATE_W-1:0] obs_state,
  input  logic               obs_lit,
  input  logic               obs_copy,
  input  logic               obs_valid,
  input  logic               cfg_we,
  input  logic [IDX_W-1:0]   cfg_addr,
  input  logic [STATE_W+1:0] cfg_data,
  input  logic [IDX_W:0]     cfg_len,
  input  logic               clr,
  output logic [1:0]         status,
  output logic [IDX_W:0]     cur_idx,
  output logic               cfg_busy
`ifdef PARSER_SEQ_CHK_CAPTURE_EN
  ,
  output logic [IDX_W-1:0]   err_idx,
  output logic [STATE_W+1:0] err_obs,
  output logic [STATE_W+1:0] err_exp
`endif
);

  localparam int TUP_W = STATE_W + 2;
  localparam logic [IDX_W:0] DEPTH_V = (IDX_W + 1)'(DEPTH);
  localparam logic [IDX_W:0] ONE_V   = (IDX_W + 1)'(1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_PASS = 2'd2,
    ST_FAIL = 2'd3
  } state_t;

  function automatic logic f_tuple_match(input logic [TUP_W-1:0] a,
                                         input logic [TUP_W-1:0] b);
    return (a == b);
  endfunction

  logic [TUP_W-1:0] r_exp [DEPTH];
  state_t           r_state;
  state_t           w_state_nxt;
  logic [IDX_W:0]   r_idx;
  logic [IDX_W:0]   w_idx_nxt;
  logic [IDX_W:0]   r_len;
  logic [IDX_W:0]   w_len_nxt;
  logic [IDX_W:0]   w_len_sat;
  logic [TUP_W-1:0] w_obs;
  logic [TUP_W-1:0] w_exp_sel;
  logic             w_match;
  logic             w_cmp_en;
  logic             w_enter_fail;

  logic [1:0]       r_status;
  logic [IDX_W:0]   r_cur_idx;
  logic             r_cfg_busy;

  assign w_obs = {obs_state, obs_lit, obs_copy};

  // Expected table: plain storage, writes locked out while a check is running.
  always_ff @(posedge clk) begin
    if (cfg_we && (r_state != ST_RUN)) begin
      r_exp[cfg_addr] <= cfg_data;
    end
  end

  // Operand selection, length saturation and compare enable.
  always_comb begin
    w_exp_sel = r_exp[{IDX_W{1'b0}}];
    if (r_state == ST_RUN) begin
      w_exp_sel = r_exp[r_idx[IDX_W-1:0]];
    end else begin
      w_exp_sel = r_exp[{IDX_W{1'b0}}];
    end
    if (cfg_len > DEPTH_V) begin
      w_len_sat = DEPTH_V;
    end else begin
      w_len_sat = cfg_len;
    end
    if (GATED) begin
      w_cmp_en = obs_valid;
    end else begin
      w_cmp_en = 1'b1;
    end
    w_match = f_tuple_match(w_obs, w_exp_sel);
  end

  // FSM next-state and index update; clr wins over any comparison.
  always_comb begin
    w_state_nxt = r_state;
    w_idx_nxt   = r_idx;
    w_len_nxt   = r_len;
    if (clr) begin
      w_state_nxt = ST_IDLE;
      w_idx_nxt   = '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (obs_valid && (cfg_len != '0)) begin
            w_len_nxt = w_len_sat;
            if (w_match) begin
              w_idx_nxt = ONE_V;
              if (w_len_sat == ONE_V) begin
                w_state_nxt = ST_PASS;
              end else begin
                w_state_nxt = ST_RUN;
              end
            end else begin
              w_idx_nxt   = '0;
              w_state_nxt = ST_FAIL;
            end
          end else begin
            w_state_nxt = ST_IDLE;
          end
        end
        ST_RUN: begin
          if (w_cmp_en) begin
            if (!w_match) begin
              w_state_nxt = ST_FAIL;
            end else if (r_idx == (r_len - ONE_V)) begin
              w_state_nxt = ST_PASS;
              w_idx_nxt   = r_len;
            end else begin
              w_idx_nxt = r_idx + ONE_V;
            end
          end else begin
            w_state_nxt = ST_RUN;
          end
        end
        ST_PASS: w_state_nxt = ST_PASS;
        ST_FAIL: w_state_nxt = ST_FAIL;
        default: begin
          w_state_nxt = ST_IDLE;
          w_idx_nxt   = '0;
        end
      endcase
    end
    w_enter_fail = (w_state_nxt == ST_FAIL) && (r_state != ST_FAIL);
  end

  // FSM state, index and latched length.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_idx   <= '0;
      r_len   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_idx   <= w_idx_nxt;
      r_len   <= w_len_nxt;
    end
  end

  // Output stage: one cycle behind the FSM decision.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_status   <= 2'd0;
      r_cur_idx  <= '0;
      r_cfg_busy <= 1'b0;
    end else begin
      r_status   <= r_state;
      r_cur_idx  <= r_idx;
      r_cfg_busy <= (r_state == ST_RUN);
    end
  end

  assign status   = r_status;
  assign cur_idx  = r_cur_idx;
  assign cfg_busy = r_cfg_busy;

`ifdef PARSER_SEQ_CHK_CAPTURE_EN
  logic [IDX_W-1:0] r_err_idx;
  logic [TUP_W-1:0] r_err_obs;
  logic [TUP_W-1:0] r_err_exp;
  logic [IDX_W-1:0] r_err_idx_o;
  logic [TUP_W-1:0] r_err_obs_o;
  logic [TUP_W-1:0] r_err_exp_o;

  // First-mismatch capture, loaded only on the edge that enters FAIL.
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      r_err_idx <= '0;
      r_err_obs <= '0;
      r_err_exp <= '0;
    end else if (w_enter_fail) begin
      r_err_idx <= r_idx[IDX_W-1:0];
      r_err_obs <= w_obs;
      r_err_exp <= w_exp_sel;
    end
  end

  // Capture outputs share the status pipeline stage.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_err_idx_o <= '0;
      r_err_obs_o <= '0;
      r_err_exp_o <= '0;
    end else begin
      r_err_idx_o <= r_err_idx;
      r_err_obs_o <= r_err_obs;
      r_err_exp_o <= r_err_exp;
    end
  end

  assign err_idx = r_err_idx_o;
  assign err_obs = r_err_obs_o;
  assign err_exp = r_err_exp_o;
`endif

endmodule

// File: tb/tb_parser_seq_checker.sv
// Scoreboard bench for parser_seq_checker: two instances (GATED=0 and GATED=1)
// share stimulus; expectations are queued with a target cycle and checked by a monitor.
module tb_parser_seq_checker;

  logic       clk;
  logic       rst;
  logic [2:0] obs_state;
  logic       obs_lit;
  logic       obs_copy;
  logic       obs_valid;
  logic       cfg_we;
  logic [3:0] cfg_addr;
  logic [4:0] cfg_data;
  logic [4:0] cfg_len;
  logic       clr;

  logic [1:0] st0, st1;
  logic [4:0] idx0, idx1;
  logic       busy0, busy1;
`ifdef PARSER_SEQ_CHK_CAPTURE_EN
  logic [3:0] eidx0, eidx1;
  logic [4:0] eobs0, eobs1, eexp0, eexp1;
`endif

  parser_seq_checker #(.STATE_W(3), .DEPTH(16), .IDX_W(4), .GATED(1'b0)) u_dut0 (
    .clk(clk), .rst(rst), .obs_state(obs_state), .obs_lit(obs_lit), .obs_copy(obs_copy),
    .obs_valid(obs_valid), .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_data(cfg_data),
    .cfg_len(cfg_len), .clr(clr), .status(st0), .cur_idx(idx0), .cfg_busy(busy0)
`ifdef PARSER_SEQ_CHK_CAPTURE_EN
    , .err_idx(eidx0), .err_obs(eobs0), .err_exp(eexp0)
`endif
  );

  parser_seq_checker #(.STATE_W(3), .DEPTH(16), .IDX_W(4), .GATED(1'b1)) u_dut1 (
    .clk(clk), .rst(rst), .obs_state(obs_state), .obs_lit(obs_lit), .obs_copy(obs_copy),
    .obs_valid(obs_valid), .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_data(cfg_data),
    .cfg_len(cfg_len), .clr(clr), .status(st1), .cur_idx(idx1), .cfg_busy(busy1)
`ifdef PARSER_SEQ_CHK_CAPTURE_EN
    , .err_idx(eidx1), .err_obs(eobs1), .err_exp(eexp1)
`endif
  );

  typedef struct {
    int          cyc;
    int          dut;
    bit          cap;
    logic [13:0] val;
    int          tag;
  } exp_t;

  exp_t q[$];
  int   cyc = 0;
  int   n_checks = 0;
  int   n_fail = 0;

  logic [4:0] seq [7] = '{5'b00100, 5'b01000, 5'b01010, 5'b01001,
                          5'b01010, 5'b01001, 5'b00110};
  logic [4:0] g_t [7] = '{5'b00100, 5'b11111, 5'b11111, 5'b01000,
                          5'b11111, 5'b11111, 5'b01010};
  logic       g_v [7] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  // Watchdog: the stimulus must reach its end in bounded time.
  initial begin
    #2000000;
    n_fail++;
    $display("FAIL timeout: stimulus did not complete");
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  function automatic logic [13:0] f_got(input int dut, input bit cap);
    logic [13:0] r;
    r = '0;
    if (!cap) begin
      if (dut == 0) r = {6'd0, st0, idx0, busy0};
      else          r = {6'd0, st1, idx1, busy1};
    end
`ifdef PARSER_SEQ_CHK_CAPTURE_EN
    else begin
      r = {eidx0, eobs0, eexp0};
    end
`endif
    return r;
  endfunction

  // Monitor: compare every queued expectation whose cycle has come.
  always @(negedge clk) begin
    for (int i = q.size() - 1; i >= 0; i--) begin
      if (q[i].cyc <= cyc) begin
        n_checks++;
        if (f_got(q[i].dut, q[i].cap) !== q[i].val) begin
          n_fail++;
          $display("FAIL chk tag=%0d dut=%0d cap=%0d cyc=%0d got=%h want=%h",
                   q[i].tag, q[i].dut, q[i].cap, cyc, f_got(q[i].dut, q[i].cap), q[i].val);
        end
        q.delete(i);
      end
    end
  end

  function automatic logic [4:0] f_pat(input int i);
    logic [31:0] v;
    v = i;
    return {v[2:0], v[3], v[0]};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_st(input int dut, input int off, input logic [1:0] st,
                           input int idx, input logic busy, input int tag);
    exp_t e;
    e.cyc = cyc + off;
    e.dut = dut;
    e.cap = 1'b0;
    e.val = {6'd0, st, 5'(idx), busy};
    e.tag = tag;
    q.push_back(e);
  endtask

  task automatic expect_cap(input int off, input logic [3:0] ei, input logic [4:0] eo,
                            input logic [4:0] ee, input int tag);
    exp_t e;
    e.cyc = cyc + off;
    e.dut = 0;
    e.cap = 1'b1;
    e.val = {ei, eo, ee};
    e.tag = tag;
    q.push_back(e);
  endtask

  task automatic smp(input logic [4:0] t, input logic v);
    obs_state = t[4:2];
    obs_lit   = t[1];
    obs_copy  = t[0];
    obs_valid = v;
  endtask

  task automatic wr(input int a, input logic [4:0] d);
    cfg_we   = 1'b1;
    cfg_addr = 4'(a);
    cfg_data = d;
    tick();
    cfg_we   = 1'b0;
  endtask

  task automatic do_clr(input int tag);
    clr = 1'b1;
    smp(5'b00000, 1'b0);
    expect_st(0, 2, 2'd0, 0, 1'b0, tag);
    expect_st(1, 2, 2'd0, 0, 1'b0, tag);
    tick();
    clr = 1'b0;
  endtask

  initial begin
    logic [4:0] t;
    int         m;
    rst = 1'b1; clr = 1'b0; cfg_we = 1'b0; cfg_addr = 4'd0; cfg_data = 5'd0;
    cfg_len = 5'd0;
    smp(5'b00000, 1'b0);
    tick(); tick();
    n_checks++;
    if ({st0, idx0, busy0} !== 8'd0 || {st1, idx1, busy1} !== 8'd0) begin
      n_fail++;
      $display("FAIL reset state: st0=%0d idx0=%0d busy0=%0b st1=%0d idx1=%0d busy1=%0b",
               st0, idx0, busy0, st1, idx1, busy1);
    end
    rst = 1'b0;
    expect_st(0, 1, 2'd0, 0, 1'b0, 1);
    expect_st(1, 1, 2'd0, 0, 1'b0, 1);
    for (int i = 0; i < 7; i++) wr(i, seq[i]);

    // Full matching sequence of 7, then post-PASS garbage is ignored.
    cfg_len = 5'd7;
    for (int i = 0; i < 7; i++) begin
      smp(seq[i], 1'b1);
      expect_st(0, 2, (i == 6) ? 2'd2 : 2'd1, i + 1, (i != 6), 10 + i);
      tick();
    end
    smp(5'b11111, 1'b1);
    expect_st(0, 2, 2'd2, 7, 1'b0, 20);
    tick();
    smp(5'b00000, 1'b0);
    tick();
    do_clr(21);
    tick();

    // Corrupted 4th sample: sticky FAIL with cur_idx 3.
    for (int i = 0; i < 5; i++) begin
      t = (i == 3) ? 5'b01000 : seq[i];
      smp(t, 1'b1);
      if (i < 3) expect_st(0, 2, 2'd1, i + 1, 1'b1, 30 + i);
      else       expect_st(0, 2, 2'd3, 3, 1'b0, 30 + i);
`ifdef PARSER_SEQ_CHK_CAPTURE_EN
      if (i == 3) expect_cap(2, 4'd3, 5'b01000, 5'b01001, 35);
`endif
      tick();
    end
    smp(5'b00000, 1'b0);
    tick();
`ifdef PARSER_SEQ_CHK_CAPTURE_EN
    expect_cap(2, 4'd0, 5'd0, 5'd0, 37);
`endif
    do_clr(36);

    // Gated compare with bubbles carrying garbage; ungated instance fails.
    cfg_len = 5'd3;
    m = 0;
    for (int k = 0; k < 7; k++) begin
      smp(g_t[k], g_v[k]);
      if (g_v[k]) m++;
      expect_st(1, 2, (m == 3) ? 2'd2 : 2'd1, m, (m != 3), 40 + k);
      expect_st(0, 2, (k == 0) ? 2'd1 : 2'd3, 1, (k == 0), 50 + k);
      tick();
    end
    tick();
    do_clr(59);

    // Table write during RUN is dropped; run still passes.
    cfg_len = 5'd7;
    for (int i = 0; i < 7; i++) begin
      smp(seq[i], 1'b1);
      if (i == 2) begin
        cfg_we = 1'b1; cfg_addr = 4'd5; cfg_data = 5'b11111;
      end
      expect_st(0, 2, (i == 6) ? 2'd2 : 2'd1, i + 1, (i != 6), 60 + i);
      tick();
      cfg_we = 1'b0;
    end
    smp(5'b00000, 1'b0);
    tick();
    do_clr(70);
    tick();
    wr(5, 5'b11111);
    cfg_len = 5'd6;
    for (int i = 0; i < 6; i++) begin
      t = (i == 5) ? 5'b11111 : seq[i];
      smp(t, 1'b1);
      expect_st(0, 2, (i == 5) ? 2'd2 : 2'd1, i + 1, (i != 5), 71 + i);
      tick();
    end
    smp(5'b00000, 1'b0);
    tick();
    do_clr(77);
    wr(5, seq[5]);

    // cfg_len=0 never starts.
    cfg_len = 5'd0;
    for (int k = 0; k < 3; k++) begin
      smp(seq[0], 1'b1);
      expect_st(0, 2, 2'd0, 0, 1'b0, 80 + k);
      tick();
    end
    smp(5'b00000, 1'b0);

    // cfg_len=20 saturates to 16.
    for (int i = 0; i < 16; i++) wr(i, f_pat(i));
    cfg_len = 5'd20;
    for (int i = 0; i < 16; i++) begin
      smp(f_pat(i), 1'b1);
      if (i == 7 || i >= 14)
        expect_st(0, 2, (i == 15) ? 2'd2 : 2'd1, i + 1, (i != 15), 90 + i);
      tick();
    end
    smp(5'b00000, 1'b0);
    tick();
    do_clr(99);

    // Reset mid-run aborts; next valid restarts at exp[0].
    for (int i = 0; i < 7; i++) wr(i, seq[i]);
    cfg_len = 5'd7;
    for (int i = 0; i < 3; i++) begin
      smp(seq[i], 1'b1);
      if (i < 2) expect_st(0, 2, 2'd1, i + 1, 1'b1, 100 + i);
      tick();
    end
    smp(seq[3], 1'b1);
    rst = 1'b1;
    expect_st(0, 2, 2'd0, 0, 1'b0, 103);
    expect_st(1, 2, 2'd0, 0, 1'b0, 103);
    tick();
    rst = 1'b0;
    for (int i = 0; i < 2; i++) begin
      smp(seq[i], 1'b1);
      expect_st(0, 2, 2'd1, i + 1, 1'b1, 104 + i);
      tick();
    end
    do_clr(106);
    repeat (4) tick();

    n_checks++;
    if (q.size() != 0) begin
      n_fail++;
      foreach (q[j]) begin
        $display("FAIL expired wait: tag=%0d dut=%0d target cyc=%0d never checked",
                 q[j].tag, q[j].dut, q[j].cyc);
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
